fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling instruction queue between the fetch stage and the decode stage of the five-stage MIPS pipeline. It buffers up to DEPTH fetched {PC+4, instruction} pairs so a decode stall does not immediately stall fetch. Fetch stalls only when the queue is full. A control-flow redirect flushes the queue.

## Interface
- DEPTH, 4, number of entries; power of two, ≥ 2
- PTR_W, 2, log2(DEPTH); width of the read and write pointers
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- push_valid  input  1  fetch stage presents a valid instruction this cycle
- push_pc4  input  32  PC+4 of the presented instruction
- push_instr  input  32  presented instruction word
- full  output  1  queue holds DEPTH entries; drives fetch stall (StallF)
- pop_ready  input  1  decode stage consumes the head entry this cycle (~StallD)
- pop_valid  output  1  head entry valid (queue non-empty)
- pop_pc4  output  32  PC+4 of head entry; 32'h0 when empty
- pop_instr  output  32  head instruction; 32'h0 (nop) when empty
- flush  input  1  redirect: discard all entries
- count  output  PTR_W+1  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry circular buffer of 64-bit {pc4, instr}. Write pointer wp and read pointer rp are PTR_W bits wide and wrap modulo DEPTH. Occupancy is held in a PTR_W+1-bit count register.
- push_fire = push_valid & ~full & ~flush. On push_fire, write the entry at wp, then wp <= wp+1.
- pop_fire = pop_valid & pop_ready & ~flush. On pop_fire, rp <= rp+1.
- count update:
  - +1 on push_fire only
  - −1 on pop_fire only
  - unchanged when both fire or neither fires
- Push is blocked while full, even if a pop fires in the same cycle. There is no full-and-pop pass-through.
- pop_valid = (count != 0). full = (count == DEPTH). Both are decoded from registered count, so they are glitch-free functions of state.
- pop_pc4 and pop_instr read the entry at rp and are forced to 0 when count == 0. Decode therefore sees a nop bubble when the queue is empty.
- Flush has priority over push and pop in the same cycle:
  - wp, rp and count are cleared to 0
  - the same-cycle push is dropped
  - the same-cycle pop is not counted
  - storage contents are left unchanged; they are unreachable after the clear
- pop_ready while empty has no effect. push_valid while full has no effect; fetch must hold its PC via full.
- Any other combination is illegal: count never exceeds DEPTH and never underflows.

## Timing
- Reset (reset = 0, asynchronous): wp = rp = 0, count = 0, pop_valid = 0, full = 0, pop_pc4 = 0, pop_instr = 0. Release is synchronous to the next rising clk.
- Latency: an entry pushed at edge N is presented at the head (pop_valid = 1) after edge N. There is no same-cycle bypass from push to pop.
- Throughput: one push and one pop per cycle when neither full nor empty.
- full asserts in the cycle after the edge that writes the DEPTH-th entry. It deasserts in the cycle after the first pop_fire or a flush.
- Flush at edge N: pop_valid = 0, full = 0 and count = 0 after edge N. A push at edge N+1 is accepted normally.
- Reset asserted mid-operation clears state immediately, regardless of clk. In-flight entries are lost.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no loss of ordering; entries pop in push order.

## Test plan
- Reset then fill: hold pop_ready = 0 and push 4 entries (pc4 0x3004/0x3008/0x300C/0x3010, instr 0x11..0x44). Required: count goes 1,2,3,4; full = 1 after the 4th edge; a 5th push (instr 0x55) is ignored; count stays 4.
- Drain in order: from full, hold pop_ready = 1 with push_valid = 0. Required: pop_instr presents 0x11, 0x22, 0x33, 0x44 on successive cycles; then pop_valid = 0 and pop_instr = 0x0; full drops after the first pop.
- Streaming: push every cycle with pop_ready = 1 for 20 cycles (instr = cycle index). Required: count holds at 1 after the first edge; output sequence equals input delayed by one cycle; pointers wrap at least 4 times.
- Simultaneous push + pop at count = 2. Required: count stays 2; head advances; the new entry is appended at the tail.
- Flush with a same-cycle push and pop at count = 3. Required: count = 0, pop_valid = 0, full = 0 next cycle; the pushed entry is not visible; the next push (instr 0xAB) appears at the head one cycle later.
- Asynchronous reset asserted between clock edges with count = 3. Required: count = 0, pop_valid = 0 and pop_instr = 0 immediately, before the next edge; normal pushes resume after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode: a DEPTH-entry circular buffer of
// {PC+4, instruction} pairs. Fetch stalls on full, and a redirect flushes the queue.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_pc4,
    input  logic [DATA_W-1:0] push_instr,
    output logic              full,
    input  logic              pop_ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_pc4,
    output logic [DATA_W-1:0] pop_instr,
    input  logic              flush,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] CNT_MAX = (PTR_W + 1)'(DEPTH);

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wp;
    logic [PTR_W-1:0]    rp;
    logic                push_fire;
    logic                pop_fire;
    logic [2*DATA_W-1:0] head;

    assign pop_valid = (count != '0);
    assign full      = (count == CNT_MAX);
    assign push_fire = push_valid & ~full & ~flush;
    assign pop_fire  = pop_valid & pop_ready & ~flush;

    // Storage is never reset; entries past rp/wp are unreachable, so stale data is harmless.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wp] <= {push_pc4, push_instr};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_fire) begin
                wp <= wp + PTR_W'(1);
            end
            if (pop_fire) begin
                rp <= rp + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head presentation: an empty queue shows decode a nop bubble.
    assign head      = mem[rp];
    assign pop_pc4   = pop_valid ? head[2*DATA_W-1:DATA_W] : '0;
    assign pop_instr = pop_valid ? head[DATA_W-1:0]        : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, drain, streaming, simultaneous push/pop,
// flush priority and asynchronous reset.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        push_valid;
    logic [31:0] push_pc4;
    logic [31:0] push_instr;
    logic        full;
    logic        pop_ready;
    logic        pop_valid;
    logic [31:0] pop_pc4;
    logic [31:0] pop_instr;
    logic        flush;
    logic [2:0]  count;

    int n_chk;
    int n_fail;

    fetch_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_pc4   (push_pc4),
        .push_instr (push_instr),
        .full       (full),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_pc4    (pop_pc4),
        .pop_instr  (pop_instr),
        .flush      (flush),
        .count      (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc4, input logic [31:0] instr);
        push_valid = 1'b1;
        push_pc4   = pc4;
        push_instr = instr;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        push_valid = 1'b0;
        push_pc4   = '0;
        push_instr = '0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        #12 reset = 1'b1;

        check("rst_count", 32'(count), 0);
        check("rst_pop_valid", 32'(pop_valid), 0);
        check("rst_full", 32'(full), 0);
        check("rst_pop_pc4", pop_pc4, 0);
        check("rst_pop_instr", pop_instr, 0);

        // Fill with pop_ready low
        for (int i = 0; i < 4; i++) begin
            push(32'h3004 + 32'(4 * i), 32'h11 * 32'(i + 1));
            tick();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_full", 32'(full), (i == 3) ? 1 : 0);
        end
        push(32'h3014, 32'h55);
        tick();
        check("full_push_count", 32'(count), 4);
        check("full_push_full", 32'(full), 1);
        check("full_head_instr", pop_instr, 32'h11);

        // Drain in order
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_instr", pop_instr, 32'h11 * 32'(i + 1));
            check("drain_pc4", pop_pc4, 32'h3004 + 32'(4 * i));
            check("drain_valid", 32'(pop_valid), 1);
            tick();
            check("drain_full", 32'(full), 0);
        end
        check("drain_empty_valid", 32'(pop_valid), 0);
        check("drain_empty_instr", pop_instr, 0);
        check("drain_empty_count", 32'(count), 0);

        // Streaming: one push and one pop per cycle
        for (int i = 0; i < 20; i++) begin
            push(32'h4000 + 32'(4 * i), 32'(i));
            tick();
            check("stream_count", 32'(count), 1);
            check("stream_instr", pop_instr, 32'(i));
        end
        push_valid = 1'b0;
        tick();
        check("stream_end_count", 32'(count), 0);

        // Simultaneous push and pop at count = 2
        pop_ready = 1'b0;
        push(32'h5004, 32'hA1);
        tick();
        push(32'h5008, 32'hA2);
        tick();
        check("pp_pre_count", 32'(count), 2);
        pop_ready = 1'b1;
        push(32'h500C, 32'hA3);
        tick();
        check("pp_count", 32'(count), 2);
        check("pp_head", pop_instr, 32'hA2);
        push_valid = 1'b0;
        tick();
        check("pp_tail_instr", pop_instr, 32'hA3);
        check("pp_tail_pc4", pop_pc4, 32'h500C);
        check("pp_tail_count", 32'(count), 1);
        tick();
        check("pp_empty_valid", 32'(pop_valid), 0);

        // Flush beats same-cycle push and pop at count = 3
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'h6004 + 32'(4 * i), 32'hB1 + 32'(i));
            tick();
        end
        check("fl_pre_count", 32'(count), 3);
        push(32'h6010, 32'hEE);
        pop_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_count", 32'(count), 0);
        check("fl_valid", 32'(pop_valid), 0);
        check("fl_full", 32'(full), 0);
        check("fl_instr", pop_instr, 0);
        pop_ready = 1'b0;
        push(32'h7004, 32'hAB);
        tick();
        check("fl_next_count", 32'(count), 1);
        check("fl_next_instr", pop_instr, 32'hAB);
        check("fl_next_pc4", pop_pc4, 32'h7004);
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        tick();
        check("fl_drain_count", 32'(count), 0);

        // Asynchronous reset between edges with count = 3
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'h8004 + 32'(4 * i), 32'hC1 + 32'(i));
            tick();
        end
        push_valid = 1'b0;
        check("ar_pre_count", 32'(count), 3);
        #2 reset = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_valid", 32'(pop_valid), 0);
        check("ar_instr", pop_instr, 0);
        #2 reset = 1'b1;
        push(32'h9004, 32'hD1);
        tick();
        check("ar_resume_count", 32'(count), 1);
        check("ar_resume_instr", pop_instr, 32'hD1);
        push_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
